// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the 7-segment scan controller.
// Leading-zero blanking helper is used only when SEG7_SCAN_LZB_EN is defined.
package seg7_pkg;

  localparam logic [3:0] SEG7_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } seg7_state_e;

  // Observation bundle: scanner state, active digit index, pending flag.
  typedef struct packed {
    seg7_state_e state;
    logic [3:0]  idx;
    logic        pend_vld;
  } seg7_dbg_t;

  // Bit i set when digit i (i>0) and every digit above it are zero.
  // Frame is zero-extended to 16 digits; digits >= 'digits' are ignored.
  function automatic logic [15:0] seg7_lzb_mask(input logic [63:0] frame,
                                                input int digits);
    logic [15:0] m;
    logic        zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = 15; i >= 1; i--) begin
      if (i < digits) begin
        zero_above = zero_above && (frame[4*i +: 4] == 4'd0);
        m[i]       = zero_above;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_slot_timer.sv
// Loadable down-counter timing the ON and GAP slots of the scanner.
// done is high while the count sits at zero (last cycle of a slot).
module seg7_slot_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Clear wins over load; otherwise count down and stick at zero.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered frames.
// Optional feature: define SEG7_SCAN_LZB_EN for leading-zero blanking.
//
// Load strobe: 'load' is a single-cycle write with no back-pressure; bcd/dot
// are captured on that cycle into the pending buffer (last write wins). The
// pending frame is copied to the displayed frame only when the scanner enters
// ON for digit 0; a load on that exact cycle bypasses straight to display.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int ON_CYCLES  = 1000,
  parameter int GAP_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [DIGITS*4-1:0] bcd,
  input  logic [DIGITS-1:0]   dot,
  output logic [3:0]          seg_bcd,
  output logic                seg_dot,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                frame_start,
  output logic                update_ack,
  output seg7_dbg_t           dbg
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;
  localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DIGITS-1:0] SEL0 = DIGITS'(1);

  seg7_state_e          state;
  logic [IW-1:0]        idx;
  logic [DIGITS*4-1:0]  disp_bcd, pend_bcd, nxt_bcd;
  logic [DIGITS-1:0]    disp_dot, pend_dot, nxt_dot;
  logic                 pend_vld;

  logic                 tmr_done, tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 on_entry, gap_entry, apply;
  logic [IW-1:0]        on_idx, idx_next;
  logic [3:0]           shown_bcd;
`ifdef SEG7_SCAN_LZB_EN
  logic [15:0]          lzb;
`endif

  seg7_slot_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!en),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Decide the next slot, the frame to show after a possible apply, and the
  // code presented for the digit being entered.
  always_comb begin
    idx_next  = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    on_entry  = 1'b0;
    gap_entry = 1'b0;
    on_idx    = idx;
    if (en) begin
      case (state)
        IDLE: begin
          on_entry = 1'b1;
          on_idx   = '0;
        end
        ON: begin
          if (tmr_done) begin
            if (GAP_CYCLES == 0) begin
              on_entry = 1'b1;
              on_idx   = idx_next;
            end else begin
              gap_entry = 1'b1;
            end
          end
        end
        GAP: begin
          if (tmr_done) begin
            on_entry = 1'b1;
            on_idx   = idx_next;
          end
        end
        default: begin
          on_entry = 1'b0;
        end
      endcase
    end
    apply    = on_entry && (on_idx == '0);
    tmr_load = on_entry || gap_entry;
    tmr_val  = on_entry ? ON_LD : GAP_LD;
    nxt_bcd  = disp_bcd;
    nxt_dot  = disp_dot;
    if (apply && load) begin
      nxt_bcd = bcd;
      nxt_dot = dot;
    end else if (apply && pend_vld) begin
      nxt_bcd = pend_bcd;
      nxt_dot = pend_dot;
    end
    shown_bcd = nxt_bcd[4*on_idx +: 4];
`ifdef SEG7_SCAN_LZB_EN
    lzb = seg7_lzb_mask(64'(nxt_bcd), DIGITS);
    if (lzb[on_idx]) shown_bcd = SEG7_BLANK;
`endif
  end

  // Scanner FSM, frame buffers and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      disp_bcd    <= {DIGITS{SEG7_BLANK}};
      disp_dot    <= '0;
      pend_bcd    <= {DIGITS{SEG7_BLANK}};
      pend_dot    <= '0;
      pend_vld    <= 1'b0;
      digit_sel   <= '0;
      seg_bcd     <= SEG7_BLANK;
      seg_dot     <= 1'b0;
      frame_start <= 1'b0;
      update_ack  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      update_ack  <= 1'b0;
      if (load) begin
        pend_bcd <= bcd;
        pend_dot <= dot;
        pend_vld <= 1'b1;
      end
      if (apply) begin
        disp_bcd    <= nxt_bcd;
        disp_dot    <= nxt_dot;
        pend_vld    <= 1'b0;
        update_ack  <= load || pend_vld;
        frame_start <= 1'b1;
      end
      if (!en) begin
        state     <= IDLE;
        idx       <= '0;
        digit_sel <= '0;
        seg_bcd   <= SEG7_BLANK;
        seg_dot   <= 1'b0;
      end else if (on_entry) begin
        state     <= ON;
        idx       <= on_idx;
        digit_sel <= SEL0 << on_idx;
        seg_bcd   <= shown_bcd;
        seg_dot   <= nxt_dot[on_idx];
      end else if (gap_entry) begin
        state     <= GAP;
        digit_sel <= '0;
        seg_bcd   <= SEG7_BLANK;
        seg_dot   <= 1'b0;
      end
    end
  end

  assign dbg.state    = state;
  assign dbg.idx      = 4'(idx);
  assign dbg.pend_vld = pend_vld;

endmodule
